apb_desc_master: RTL and testbench
==================================

// Module: apb_desc_master
// PURPOSE
// Initiator that drives the byte-wide data memory's read/write ports and turns its contents into APB traffic.
// On start, walks a list of 2-byte descriptors in data memory and issues one APB transfer per descriptor.
// APB read results are written back into the descriptor's data byte.
// Sits between the data memory (as its only requester) and the APB bus (as the sole master).
// PARAMETERS
// MEM_AW      8   data-memory address width; descriptor addresses wrap modulo 2**MEM_AW
// DW          8   data width (memory bytes, PWDATA/PRDATA)
// PAW         7   APB address width (taken from descriptor byte 0 [6:0])
// TIMEOUT     16  max ACCESS cycles waiting for PREADY before abort
// PORTS
// clk             in   1       rising-edge clock
// rst             in   1       synchronous active-high reset
// start           in   1       1-cycle pulse; accepted only in IDLE
// base_addr       in   MEM_AW  memory address of descriptor 0
// count           in   8       number of descriptors; 0 = none
// busy            out  1       high from start acceptance until done pulse
// done            out  1       1-cycle pulse at end of list or abort
// error           out  1       sticky until next accepted start: PSLVERR or timeout seen
// err_index       out  8       index of descriptor that failed (valid when error=1)
// mem_read        out  1       1-cycle read strobe to data memory
// mem_read_addr   out  MEM_AW  read address
// mem_read_data   in   DW      sampled exactly 1 cycle after mem_read
// mem_write       out  1       1-cycle write strobe to data memory
// mem_write_addr  out  MEM_AW  write address
// mem_write_data  out  DW      write data
// paddr           out  PAW     APB address
// psel            out  1       APB select
// penable         out  1       APB enable
// pwrite          out  1       APB direction, 1 = write
// pwdata          out  DW      APB write data
// prdata          in   DW      APB read data
// pready          in   1       APB ready
// pslverr         in   1       APB error (sampled with pready)
// BEHAVIOUR
// Reset: all outputs 0; state IDLE; index/timer cleared. rst mid-transfer drops psel/penable same edge.
// Descriptor i at A = base_addr + 2*i (mod 2**MEM_AW): byte A = {wr, addr[6:0]}, byte A+1 = data.
// States: IDLE -> RD_CTRL -> WT_CTRL -> RD_DATA -> WT_DATA -> SETUP -> ACCESS -> (WB) -> NEXT.
// IDLE: start & count!=0 -> RD_CTRL, busy=1, error cleared. start & count==0 -> done pulse next cycle, busy stays 0.
// RD_CTRL: mem_read=1, addr A. WT_CTRL: latch wr/addr from mem_read_data.
// RD_DATA: mem_read=1, addr A+1. WT_DATA: latch data byte (used as pwdata when wr=1).
// SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable. Always exactly 1 cycle.
// ACCESS: psel=1, penable=1; all APB outputs held stable until pready=1.
//   pready & pslverr: error=1, err_index=i, abort -> IDLE with done pulse.
//   pready & !pslverr & wr=0: capture prdata -> WB. pready & wr=1 -> NEXT.
//   TIMEOUT consecutive ACCESS cycles without pready: same as pslverr abort.
// WB: mem_write=1 for 1 cycle, addr A+1, data = captured prdata.
// NEXT: psel=penable=0; i==count-1 -> IDLE, done=1 same cycle, busy=0 after; else i++ -> RD_CTRL.
// psel never held high between transfers (no back-to-back ACCESS->ACCESS).
// mem_read and mem_write never asserted in the same cycle.
// start while busy: ignored. count/base_addr sampled only at acceptance.
// Latency, good write descriptor: 7 cycles (0 wait states); read: 8 cycles incl. WB.
// count=255 with base_addr=0xFF: descriptor addresses wrap through 0x00.
// TESTING
// Mem[0x10]=0x85,[0x11]=0x3C, count=1, pready=1 -> APB write paddr=0x05 pwdata=0x3C, done after 7 cycles.
// Mem[0x20]=0x12, count=1, slave returns prdata=0xA7 -> mem_write addr 0x21 data 0xA7; pwrite=0.
// 3 descriptors, slave inserts 2 wait states on #1 -> APB outputs stable during waits; 3 transfers in order.
// pslverr on descriptor 1 of 3 -> error=1, err_index=1, done pulse, descriptor 2 never issued.
// pready held 0 -> abort after 16 ACCESS cycles, error=1; rst mid-ACCESS -> psel=0, busy=0 next cycle.
// base_addr=0xFE, count=2 -> descriptor 1 fetched from 0x00/0x01; count=0 -> done pulse, no mem/APB activity.

Source files
------------

// File: rtl/apb_desc_master.sv
// Descriptor-driven APB master: fetches 2-byte descriptors from a byte-wide memory,
// issues one APB transfer per descriptor and writes read data back into the descriptor.
module apb_desc_master #(
  parameter int MEM_AW  = 8,
  parameter int DW      = 8,
  parameter int PAW     = 7,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW-1:0] base_addr,
  input  logic [7:0]        count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_index,
  output logic              mem_read,
  output logic [MEM_AW-1:0] mem_read_addr,
  input  logic [DW-1:0]     mem_read_data,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_write_addr,
  output logic [DW-1:0]     mem_write_data,
  output logic [PAW-1:0]    paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DW-1:0]     pwdata,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_CTRL = 4'd1;
  localparam logic [3:0] S_WT_CTRL = 4'd2;
  localparam logic [3:0] S_RD_DATA = 4'd3;
  localparam logic [3:0] S_WT_DATA = 4'd4;
  localparam logic [3:0] S_SETUP   = 4'd5;
  localparam logic [3:0] S_ACCESS  = 4'd6;
  localparam logic [3:0] S_WB      = 4'd7;
  localparam logic [3:0] S_NEXT    = 4'd8;

  typedef struct packed {
    logic           wr;
    logic [PAW-1:0] addr;
    logic [DW-1:0]  data;
  } desc_t;

  logic [3:0]        state;
  logic [7:0]        idx, last_idx;
  logic [MEM_AW-1:0] cur_addr;
  desc_t             desc;
  logic [DW-1:0]     rdata_q;
  logic [TW-1:0]     timer;
  logic              done_q;
  logic              last;

  assign last = (idx == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      last_idx  <= '0;
      cur_addr  <= '0;
      desc      <= '0;
      rdata_q   <= '0;
      timer     <= '0;
      error     <= 1'b0;
      err_index <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (count != 8'd0) begin
            state     <= S_RD_CTRL;
            idx       <= '0;
            last_idx  <= count - 8'd1;
            cur_addr  <= base_addr;
            error     <= 1'b0;
            err_index <= '0;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_RD_CTRL: state <= S_WT_CTRL;
        S_WT_CTRL: begin
          desc.wr   <= mem_read_data[DW-1];
          desc.addr <= mem_read_data[PAW-1:0];
          state     <= S_RD_DATA;
        end
        S_RD_DATA: state <= S_WT_DATA;
        S_WT_DATA: begin
          desc.data <= mem_read_data;
          state     <= S_SETUP;
        end
        S_SETUP: begin
          timer <= '0;
          state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            timer <= '0;
            if (pslverr) begin
              error     <= 1'b1;
              err_index <= idx;
              done_q    <= 1'b1;
              state     <= S_IDLE;
            end else if (!desc.wr) begin
              rdata_q <= prdata;
              state   <= S_WB;
            end else begin
              state <= S_NEXT;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // Timeout aborts exactly like a slave error.
            error     <= 1'b1;
            err_index <= idx;
            done_q    <= 1'b1;
            state     <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WB: state <= S_NEXT;
        S_NEXT: begin
          if (last) begin
            state <= S_IDLE;
          end else begin
            idx      <= idx + 8'd1;
            cur_addr <= cur_addr + MEM_AW'(2);
            state    <= S_RD_CTRL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state so reset drops the bus on the same edge.
  assign busy           = (state != S_IDLE);
  assign done           = done_q | ((state == S_NEXT) && last);
  assign mem_read       = (state == S_RD_CTRL) || (state == S_RD_DATA);
  assign mem_read_addr  = (state == S_RD_CTRL) ? cur_addr :
                          (state == S_RD_DATA) ? cur_addr + MEM_AW'(1) : '0;
  assign mem_write      = (state == S_WB);
  assign mem_write_addr = mem_write ? cur_addr + MEM_AW'(1) : '0;
  assign mem_write_data = mem_write ? rdata_q : '0;
  assign psel           = (state == S_SETUP) || (state == S_ACCESS);
  assign penable        = (state == S_ACCESS);
  assign paddr          = psel ? desc.addr : '0;
  assign pwrite         = psel ? desc.wr : 1'b0;
  assign pwdata         = psel ? desc.data : '0;

endmodule

// File: tb/tb_apb_desc_master.sv
// Scoreboard bench for apb_desc_master: memory and APB slave models, expected
// transfers/write-backs queued at setup and popped as the DUT produces them.
module tb_apb_desc_master;
  logic       clk = 0, rst = 1, start = 0;
  logic [7:0] base_addr = 0, count = 0;
  logic       busy, done, error;
  logic [7:0] err_index;
  logic       mem_read, mem_write;
  logic [7:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
  logic [6:0] paddr;
  logic       psel, penable, pwrite;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr;

  apb_desc_master dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [6:0] a; logic [7:0] d; } xfer_t;
  typedef struct { logic [7:0] a; logic [7:0] d; } mw_t;
  xfer_t exp_apb[$];
  mw_t   exp_mw[$];

  logic [7:0] mem [256];
  int   nchk = 0, nerr = 0;
  int   waits[8];
  logic [7:0] rdv[8];
  int   err_at = -1;
  bit   hang = 0;
  int   xfer_n = 0, wcnt = 0, act = 0;
  logic [15:0] snap;
  bit   busy_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mem_read) mem_read_data <= mem[mem_read_addr];
    if (mem_write) mem[mem_write_addr] <= mem_write_data;
  end

  // APB slave + monitor, evaluated mid-cycle for the coming edge.
  always @(negedge clk) begin
    xfer_t x;
    mw_t   m;
    pready = 0; pslverr = 0; prdata = 0;
    if (mem_read || mem_write || psel) act++;
    if (mem_read || mem_write) chk("mem_mutex", {31'd0, mem_read & mem_write}, 0);
    if (psel && !penable) begin
      snap = {paddr, pwrite, pwdata};
      wcnt = 0;
    end
    if (psel && penable) begin
      chk("apb_stable", {16'd0, paddr, pwrite, pwdata}, {16'd0, snap});
      if (!hang && wcnt >= waits[xfer_n]) begin
        pready  = 1;
        pslverr = (xfer_n == err_at);
        prdata  = rdv[xfer_n];
        if (exp_apb.size() == 0) chk("apb_unexp", exp_apb.size(), 1);
        else begin
          x = exp_apb.pop_front();
          chk("pwrite", pwrite, x.wr);
          chk("paddr", paddr, x.a);
          if (x.wr) chk("pwdata", pwdata, x.d);
        end
        xfer_n++;
      end else wcnt++;
    end
    if (mem_write) begin
      if (exp_mw.size() == 0) chk("mw_unexp", exp_mw.size(), 1);
      else begin
        m = exp_mw.pop_front();
        chk("mw_addr", mem_write_addr, m.a);
        chk("mw_data", mem_write_data, m.d);
      end
    end
  end

  task automatic clr();
    exp_apb.delete(); exp_mw.delete();
    for (int i = 0; i < 8; i++) begin waits[i] = 0; rdv[i] = 0; end
    err_at = -1; hang = 0;
  endtask

  // Place a descriptor; queue its expected transfer and write-back when they should occur.
  task automatic desc(input logic [7:0] a, input int n, input logic wr, input logic [6:0] pa,
                      input logic [7:0] d, input logic [7:0] rv, input bit issued, input bit wb);
    logic [7:0] a1;
    xfer_t x;
    mw_t m;
    a1 = a + 8'd1;
    mem[a] = {wr, pa};
    mem[a1] = d;
    rdv[n] = rv;
    x.wr = wr; x.a = pa; x.d = d;
    if (issued) exp_apb.push_back(x);
    m.a = a1; m.d = rv;
    if (wb) exp_mw.push_back(m);
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] c, input int exp_lat, input bit poke);
    int n;
    bit got;
    xfer_n = 0;
    @(negedge clk);
    start = 1; base_addr = b; count = c;
    n = 0; got = 0;
    while (!got && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke && n == 3) begin start = 1; base_addr = 8'h00; count = 8'd5; end
      else start = 0;
      if (done) begin got = 1; busy_at_done = busy; end
    end
    start = 0;
    chk("done_seen", got, 1);
    chk("latency", n, exp_lat);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("apb_left", exp_apb.size(), 0);
    chk("mw_left", exp_mw.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {error, err_index}, 0);
    chk("rst_bus", {psel, penable, mem_read, mem_write}, 0);
    rst = 0;

    // single write descriptor
    clr();
    desc(8'h10, 0, 1'b1, 7'h05, 8'h3C, 8'h00, 1, 0);
    run(8'h10, 8'd1, 7, 0);
    chk("wr_err", error, 0);

    // single read descriptor with write-back
    clr();
    desc(8'h20, 0, 1'b0, 7'h12, 8'h00, 8'hA7, 1, 1);
    run(8'h20, 8'd1, 8, 0);
    chk("wb_mem", mem[8'h21], 8'hA7);

    // three descriptors, wait states on #1, start ignored while busy
    clr();
    desc(8'h40, 0, 1'b1, 7'h11, 8'h5A, 8'h00, 1, 0);
    desc(8'h42, 1, 1'b0, 7'h22, 8'h00, 8'h3B, 1, 1);
    desc(8'h44, 2, 1'b1, 7'h33, 8'hC4, 8'h00, 1, 0);
    waits[1] = 2;
    run(8'h40, 8'd3, 24, 1);
    chk("three_xfers", xfer_n, 3);
    chk("three_wb", mem[8'h43], 8'h3B);

    // slave error on descriptor 1 of 3
    clr();
    desc(8'h50, 0, 1'b1, 7'h01, 8'h11, 8'h00, 1, 0);
    desc(8'h52, 1, 1'b0, 7'h02, 8'h00, 8'hEE, 1, 0);
    desc(8'h54, 2, 1'b1, 7'h03, 8'h33, 8'h00, 0, 0);
    err_at = 1;
    run(8'h50, 8'd3, 14, 0);
    chk("slverr_error", error, 1);
    chk("slverr_index", err_index, 1);
    chk("slverr_xfers", xfer_n, 2);
    chk("slverr_nowb", mem[8'h53], 8'h00);

    // timeout: pready never rises
    clr();
    desc(8'h60, 0, 1'b1, 7'h07, 8'h77, 8'h00, 0, 0);
    hang = 1;
    run(8'h60, 8'd1, 22, 0);
    chk("to_error", error, 1);
    chk("to_index", err_index, 0);

    // wrap through 0x00, error cleared by new start
    clr();
    desc(8'hFE, 0, 1'b0, 7'h44, 8'h00, 8'h99, 1, 1);
    desc(8'h00, 1, 1'b1, 7'h55, 8'h66, 8'h00, 1, 0);
    run(8'hFE, 8'd2, 15, 0);
    chk("wrap_err", error, 0);
    chk("wrap_wb", mem[8'hFF], 8'h99);

    // reset during ACCESS
    clr();
    desc(8'h70, 0, 1'b1, 7'h0A, 8'hAA, 8'h00, 0, 0);
    hang = 1; xfer_n = 0;
    @(negedge clk);
    start = 1; base_addr = 8'h70; count = 8'd1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(psel && penable) && n < 50) begin @(negedge clk); n++; end
    chk("rst_reach_access", {psel, penable}, 2'b11);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_psel", {psel, penable}, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    hang = 0;

    // count = 0: done pulse only, no traffic
    clr();
    act = 0;
    run(8'h10, 8'd0, 1, 0);
    chk("cnt0_busy", busy_at_done, 0);
    chk("cnt0_act", act, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
